// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the fetch-stage hazard controller.
package if_ctrl_pkg;

  // Controller states: normal operation, or the extra stall cycle of a
  // load feeding a branch comparison in ID.
  typedef enum logic {
    RUN       = 1'b0,
    LDBR_WAIT = 1'b1
  } ctrl_state_t;

  // Architectural zero register; writes to it never create a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Sequential PC increment used by the fetch stage this block controls.
  localparam int PC_STEP = 4;

  // True when a producer writing dst creates a dependency on source src.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/if_hazard_ctrl.sv
// Fetch-stage hazard and redirect controller for the 5-stage pipeline.
// Stalls IF/ID on load-use and branch-operand hazards, sequences the
// two-cycle load-to-branch stall, and redirects on beq/j resolved in ID.
module if_hazard_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_memRead,
  input  logic             ex_regWrite,
  input  logic [4:0]       ex_dst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_usesRt,
  input  logic             id_branch,
  input  logic             id_regEq,
  input  logic             id_jmp,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             PcSrc,
  output logic             jmp,
  output logic             flush,
  output logic             idBubble,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;

  logic match;
  logic hz_lu;
  logic hz_br;
  logic hz_brld;
  logic stall;
  logic redirect_br;
  logic redirect_j;
  logic stall_evt;
  logic flush_evt;

  // Hazard detection against the instruction currently in EX.
  always_comb begin
    match   = reg_hit(ex_dst, id_rs) | (id_usesRt & reg_hit(ex_dst, id_rt));
    hz_lu   = ex_memRead & match & ~id_jmp;
    hz_br   = id_branch & ~id_jmp & ex_regWrite & ~ex_memRead & match;
    hz_brld = id_branch & hz_lu;
  end

  // Next-state logic and control outputs; reset forces a squashing bubble.
  always_comb begin
    state_next  = state_reg;
    stall       = 1'b0;
    redirect_br = 1'b0;
    redirect_j  = 1'b0;
    pcWrite     = 1'b0;
    ifidWrite   = 1'b0;
    PcSrc       = 1'b0;
    jmp         = 1'b0;
    flush       = 1'b1;
    idBubble    = 1'b1;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;

    case (state_reg)
      RUN: begin
        stall = hz_lu | hz_br;
        if (hz_brld) begin
          state_next = LDBR_WAIT;
        end
      end
      LDBR_WAIT: begin
        // Second cycle of the load-to-branch stall: the loaded value only
        // reaches the ID comparator after this, whatever EX now holds.
        stall      = 1'b1;
        state_next = RUN;
      end
      default: begin
        stall      = 1'b1;
        state_next = RUN;
      end
    endcase

    // jmp takes priority over a taken branch in the same instruction slot.
    redirect_j  = id_jmp;
    redirect_br = id_branch & id_regEq & ~id_jmp;

    if (rst) begin
      if (stall) begin
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        idBubble  = 1'b1;
        PcSrc     = 1'b0;
        jmp       = 1'b0;
        flush     = 1'b0;
      end else begin
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        idBubble  = 1'b0;
        PcSrc     = redirect_br;
        jmp       = redirect_j;
        flush     = redirect_br | redirect_j;
      end
      stall_evt = stall;
      flush_evt = ~stall & (redirect_br | redirect_j);
    end
  end

  // State register; reset returns to RUN and drops any pending second stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Performance counters, fed only from internal events so the control
  // outputs never depend on counter values.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_evt),
    .cnt (stallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_evt),
    .cnt (flushCnt)
  );

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Self-checking bench for if_hazard_ctrl: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_if_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ex_memRead, ex_regWrite;
  logic [4:0] ex_dst, id_rs, id_rt;
  logic       id_usesRt, id_branch, id_regEq, id_jmp;

  logic        pcWrite, ifidWrite, PcSrc, jmp, flush, idBubble;
  logic [15:0] stallCnt, flushCnt;
  logic        s_pcWrite, s_ifidWrite, s_PcSrc, s_jmp, s_flush, s_idBubble;
  logic [1:0]  s_stallCnt, s_flushCnt;

  if_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite), .ex_dst(ex_dst),
    .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
    .id_branch(id_branch), .id_regEq(id_regEq), .id_jmp(id_jmp),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .PcSrc(PcSrc), .jmp(jmp),
    .flush(flush), .idBubble(idBubble), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  if_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite), .ex_dst(ex_dst),
    .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
    .id_branch(id_branch), .id_regEq(id_regEq), .id_jmp(id_jmp),
    .pcWrite(s_pcWrite), .ifidWrite(s_ifidWrite), .PcSrc(s_PcSrc), .jmp(s_jmp),
    .flush(s_flush), .idBubble(s_idBubble), .stallCnt(s_stallCnt), .flushCnt(s_flushCnt)
  );

  int total = 0;
  int bad   = 0;

  // Model: count of unconditional stall cycles still owed, plus plain
  // integer event counts that are clipped to the counter width on compare.
  int m_owed = 0;
  int m_stalls = 0;
  int m_flushes = 0;
  bit m_st, m_lu, m_fl;

  typedef struct {
    string      name;
    logic       mr, rw;
    logic [4:0] dst, rs, rt;
    logic       ut, br, eq, jp;
    logic       e_pcw, e_pcs, e_jmp, e_fl;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input string n, input logic mr, input logic rw,
                              input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ut, input logic br, input logic eq, input logic jp,
                              input logic pcw, input logic pcs, input logic j, input logic fl);
    vec_t v;
    v.name = n; v.mr = mr; v.rw = rw; v.dst = dst; v.rs = rs; v.rt = rt;
    v.ut = ut; v.br = br; v.eq = eq; v.jp = jp;
    v.e_pcw = pcw; v.e_pcs = pcs; v.e_jmp = j; v.e_fl = fl;
    return v;
  endfunction

  function automatic int clip(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic set_in(input logic mr, input logic rw, input logic [4:0] dst,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                        input logic br, input logic eq, input logic jp);
    ex_memRead = mr; ex_regWrite = rw; ex_dst = dst; id_rs = rs; id_rt = rt;
    id_usesRt = ut; id_branch = br; id_regEq = eq; id_jmp = jp;
  endtask

  task automatic idle_in();
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  // One clock: compare everything against the model at the falling edge,
  // then advance the model at the rising edge. Returns at posedge + 1.
  task automatic tick();
    bit match, hb, pcs, j;
    @(negedge clk);
    if (!rst) begin
      m_owed = 0; m_stalls = 0; m_flushes = 0;
      m_st = 0; m_lu = 0; m_fl = 0;
      chk("rst_pcWrite", pcWrite, 0);
      chk("rst_ifidWrite", ifidWrite, 0);
      chk("rst_PcSrc", PcSrc, 0);
      chk("rst_jmp", jmp, 0);
      chk("rst_flush", flush, 1);
      chk("rst_idBubble", idBubble, 1);
      chk("rst_stallCnt", stallCnt, 0);
      chk("rst_flushCnt", flushCnt, 0);
      chk("rst_sat_stallCnt", s_stallCnt, 0);
    end else begin
      match = (ex_dst != 0) && ((ex_dst == id_rs) || (id_usesRt && ex_dst == id_rt));
      m_lu  = ex_memRead && match && !id_jmp;
      hb    = id_branch && !id_jmp && ex_regWrite && !ex_memRead && match;
      m_st  = (m_owed > 0) || m_lu || hb;
      pcs   = !m_st && id_branch && id_regEq && !id_jmp;
      j     = !m_st && id_jmp;
      m_fl  = pcs || j;
      chk("pcWrite", pcWrite, !m_st);
      chk("ifidWrite", ifidWrite, !m_st);
      chk("idBubble", idBubble, m_st);
      chk("PcSrc", PcSrc, pcs);
      chk("jmp", jmp, j);
      chk("flush", flush, m_fl);
      chk("stallCnt", stallCnt, clip(m_stalls, 16));
      chk("flushCnt", flushCnt, clip(m_flushes, 16));
      chk("sat_stallCnt", s_stallCnt, clip(m_stalls, 2));
      chk("sat_flushCnt", s_flushCnt, clip(m_flushes, 2));
      chk("sat_pcWrite", s_pcWrite, !m_st);
    end
    @(posedge clk);
    if (rst) begin
      if (m_owed > 0) m_owed--;
      else if (m_st && id_branch && m_lu) m_owed = 1;
      if (m_st) m_stalls++;
      if (m_fl) m_flushes++;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    #1;
    tick();
    tick();
    rst = 1'b1;

    // Single-cycle vector table, all starting from RUN.
    tbl[0]  = mk("idle",          0,0,5'd0,5'd0,5'd0, 0,0,0,0, 1,0,0,0);
    tbl[1]  = mk("lu_rs",         1,0,5'd8,5'd8,5'd0, 0,0,0,0, 0,0,0,0);
    tbl[2]  = mk("lu_rt_unused",  1,0,5'd8,5'd3,5'd8, 0,0,0,0, 1,0,0,0);
    tbl[3]  = mk("lu_rt_used",    1,0,5'd8,5'd3,5'd8, 1,0,0,0, 0,0,0,0);
    tbl[4]  = mk("lu_r0",         1,0,5'd0,5'd0,5'd0, 1,0,0,0, 1,0,0,0);
    tbl[5]  = mk("alu_nobranch",  0,1,5'd9,5'd9,5'd0, 0,0,0,0, 1,0,0,0);
    tbl[6]  = mk("alu_branch",    0,1,5'd9,5'd9,5'd0, 0,1,0,0, 0,0,0,0);
    tbl[7]  = mk("beq_taken",     0,1,5'd5,5'd1,5'd2, 1,1,1,0, 1,1,0,1);
    tbl[8]  = mk("beq_nottaken",  0,1,5'd5,5'd1,5'd2, 1,1,0,0, 1,0,0,0);
    tbl[9]  = mk("jump",          0,0,5'd0,5'd0,5'd0, 0,0,0,1, 1,0,1,1);
    tbl[10] = mk("jump_over_beq", 0,0,5'd0,5'd1,5'd1, 1,1,1,1, 1,0,1,1);
    tbl[11] = mk("jump_lu_exempt",1,0,5'd4,5'd4,5'd0, 0,0,0,1, 1,0,1,1);
    tbl[12] = mk("jump_br_exempt",0,1,5'd6,5'd6,5'd0, 0,1,1,1, 1,0,1,1);
    tbl[13] = mk("lu_nomatch_beq",1,0,5'd7,5'd1,5'd2, 1,1,1,0, 1,1,0,1);

    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].mr, tbl[i].rw, tbl[i].dst, tbl[i].rs, tbl[i].rt,
             tbl[i].ut, tbl[i].br, tbl[i].eq, tbl[i].jp);
      #2;
      chk({"tbl_pcWrite_", tbl[i].name}, pcWrite, tbl[i].e_pcw);
      chk({"tbl_PcSrc_", tbl[i].name}, PcSrc, tbl[i].e_pcs);
      chk({"tbl_jmp_", tbl[i].name}, jmp, tbl[i].e_jmp);
      chk({"tbl_flush_", tbl[i].name}, flush, tbl[i].e_fl);
      tick();
    end

    // Load-use: one stall cycle, then free-running.
    do_reset();
    set_in(1, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0);
    tick();
    idle_in();
    #2;
    chk("lu_release_pcWrite", pcWrite, 1);
    chk("lu_stallCnt", stallCnt, 1);
    tick();

    // ALU result feeding a branch: one stall, then redirect.
    do_reset();
    set_in(0, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0);
    tick();
    set_in(0, 0, 5'd0, 5'd9, 5'd0, 0, 1, 1, 0);
    #2;
    chk("albr_PcSrc", PcSrc, 1);
    chk("albr_flush", flush, 1);
    tick();
    chk("albr_flushCnt", flushCnt, 1);
    chk("albr_stallCnt", stallCnt, 1);

    // Load feeding a branch: two stalls even after EX clears, then redirect.
    do_reset();
    set_in(1, 0, 5'd10, 5'd1, 5'd10, 1, 1, 0, 0);
    tick();
    set_in(0, 0, 5'd0, 5'd1, 5'd10, 1, 1, 0, 0);
    #2;
    chk("ldbr_second_stall", pcWrite, 0);
    tick();
    set_in(0, 0, 5'd0, 5'd1, 5'd10, 1, 1, 1, 0);
    #2;
    chk("ldbr_redirect_PcSrc", PcSrc, 1);
    chk("ldbr_stallCnt", stallCnt, 2);
    tick();
    chk("ldbr_flushCnt", flushCnt, 1);

    // Reset asserted during the second load-to-branch stall cycle.
    do_reset();
    set_in(1, 0, 5'd10, 5'd1, 5'd10, 1, 1, 0, 0);
    tick();
    tick();
    set_in(1, 0, 5'd10, 5'd1, 5'd10, 1, 1, 0, 0);
    tick();
    rst = 1'b0;
    idle_in();
    #1;
    chk("midrst_pcWrite", pcWrite, 0);
    chk("midrst_flush", flush, 1);
    chk("midrst_idBubble", idBubble, 1);
    chk("midrst_stallCnt", stallCnt, 0);
    tick();
    rst = 1'b1;
    #2;
    chk("midrst_release_pcWrite", pcWrite, 1);
    tick();

    // Saturation of the narrow counter instance.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0);
      tick();
    end
    chk("sat_stallCnt_5", s_stallCnt, 3);
    chk("wide_stallCnt_5", stallCnt, 5);
    tick();
    chk("sat_stallCnt_hold", s_stallCnt, 3);

    // Randomized run with a compact register space to provoke matches.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 39) != 0);
      tick();
    end
    rst = 1'b1;
    idle_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_hazard_ctrl.md
Name: if_hazard_ctrl

Overview:
Hazard and redirect controller for the fetch stage of the 5-stage MIPS pipeline. It drives the IF stage's pcWrite, PcSrc, jmp and flush inputs, and the IF/ID write enable. It also drives a control bubble into ID/EX.
- Detects load-use hazards and branch-operand hazards, and resolves beq/j redirects in ID.
- A small FSM sequences the two-cycle load-to-branch stall.
- Saturating stall and flush counters support performance debug.

Parameters:
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
ex_memRead  in  1  instruction in EX is a load
ex_regWrite  in  1  instruction in EX writes a register
ex_dst  in  5  destination register of the EX instruction
id_rs  in  5  rs field of the ID instruction
id_rt  in  5  rt field of the ID instruction
id_usesRt  in  1  ID instruction reads rt as a source
id_branch  in  1  ID instruction is beq
id_regEq  in  1  ID comparator result, rs==rt
id_jmp  in  1  ID instruction is j
pcWrite  out  1  PC register enable
ifidWrite  out  1  IF/ID register enable
PcSrc  out  1  select branch target
jmp  out  1  select jump target
flush  out  1  squash the instruction fetched this cycle
idBubble  out  1  zero the ID/EX control fields
stallCnt  out  CNT_W  number of stall cycles
flushCnt  out  CNT_W  number of redirect cycles

Behaviour:
- match = ex_dst!=0 & (ex_dst==id_rs | (id_usesRt & ex_dst==id_rt)).
- hz_lu = ex_memRead & match & !id_jmp.
- hz_br = id_branch & !id_jmp & ex_regWrite & !ex_memRead & match.
- hz_brld = id_branch & hz_lu.
- FSM states are RUN and LDBR_WAIT; reset state is RUN.
- RUN, when hz_lu or hz_br: stall this cycle.
  - If hz_brld, next state is LDBR_WAIT; otherwise remain in RUN.
- LDBR_WAIT: stall unconditionally, regardless of the EX inputs; next state is RUN.
- Stall cycle outputs: pcWrite=0, ifidWrite=0, idBubble=1, PcSrc=0, jmp=0, flush=0.
- Non-stall cycle outputs (all combinational, same cycle):
  - pcWrite=1, ifidWrite=1, idBubble=0.
  - jmp=id_jmp.
  - PcSrc=id_branch & id_regEq & !id_jmp; jmp wins if both id_branch and id_jmp are asserted.
  - flush=PcSrc|jmp.
- Counters:
  - stallCnt increments on every stall cycle.
  - flushCnt increments on every cycle with flush=1.
  - Both saturate at all-ones and never wrap.
- Reset (rst=0, asynchronous):
  - State goes to RUN and both counters go to 0.
  - While rst=0, outputs are forced to pcWrite=0, ifidWrite=0, PcSrc=0, jmp=0, flush=1, idBubble=1.
  - Reset asserted during LDBR_WAIT abandons the second stall cycle.
- Register $0 never causes a hazard.
- No combinational path exists from the counters to the control outputs.

Decomposition:
- if_ctrl_pkg holds:
  - the state enum {RUN, LDBR_WAIT};
  - REG_ZERO = 5'd0;
  - PC_STEP = 4.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, cnt), is instantiated twice, once per counter.

Test Plan:
- Load-use stall:
  - Stimulus: ex_memRead=1, ex_dst=8, id_rs=8, no branch, for one cycle; then ex_memRead=0.
  - Response: one cycle with pcWrite=0, ifidWrite=0, idBubble=1; next cycle pcWrite=1; stallCnt=1.
- ALU result feeding a branch:
  - Stimulus: id_branch=1, id_rs=9, ex_regWrite=1, ex_memRead=0, ex_dst=9; next cycle EX clears and id_regEq=1.
  - Response: one stall cycle, then PcSrc=1, flush=1; flushCnt=1.
- Load feeding a branch:
  - Stimulus: id_branch=1, id_usesRt=1, id_rt=10, ex_memRead=1, ex_dst=10; EX inputs drop to 0 in the next cycle.
  - Response: two stall cycles regardless; redirect on the third cycle; stallCnt=2.
- $0 and jump exemptions:
  - Stimulus A: ex_memRead=1, ex_dst=0, id_rs=0. Response: no stall.
  - Stimulus B: id_jmp=1 with ex_dst==id_rs and ex_memRead=1. Response: jmp=1, flush=1, pcWrite=1.
- Reset mid-stall:
  - Stimulus: drop rst during LDBR_WAIT.
  - Response: outputs immediately take the forced reset values and counters read 0; after release, state is RUN and pcWrite=1.
- Saturation:
  - Stimulus: CNT_W=2, five stall cycles.
  - Response: stallCnt=3 and holds at 3.
